// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the bootable instruction memory.
// Consumers: instr_mem_boot and its testbench.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IMEM_INIT = 2'd0,
    IMEM_BOOT = 2'd1,
    IMEM_RUN  = 2'd2
  } imem_state_e;

  // addi x0,x0,0: fill value after reset and the value returned on a fault.
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  localparam int unsigned IMEM_PAR_MAX_W = 64;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [IMEM_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Synchronous storage array for the instruction memory.
// One write port and one registered read port; the array has no reset.
module imem_ram_1r1w #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read data only updates on a read, so the output holds between fetches.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_boot.sv
// Instruction memory with an INIT -> BOOT -> RUN lifecycle and fault-reporting fetch port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_mem_boot
  import instr_mem_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 256,
  parameter logic [XLEN-1:0] NOP_WORD    = XLEN'(IMEM_NOP_WORD),
  localparam int unsigned    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            boot_we_i,
  input  logic [AW-1:0]   boot_addr_i,
  input  logic [XLEN-1:0] boot_data_i,
  input  logic            boot_done_i,
  output logic            boot_ready_o,
  output logic            ready_o,
  input  logic            fetch_req_i,
  input  logic [31:0]     fetch_addr_i,
  output logic            fetch_gnt_o,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] instruction_o,
`ifdef IMEM_PARITY_EN
  output logic            parity_err_o,
`endif
  output logic            fetch_err_o
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = XLEN + 1;
`else
  localparam int unsigned MEM_W = XLEN;
`endif

  imem_state_e     state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            boot_ready_q, ready_q, valid_q;
  logic            nop_sel_q, addr_err_q;
  logic            ram_we_s, ram_re_s;
  logic [AW-1:0]   ram_waddr_s;
  logic [XLEN-1:0] wdata_raw_s;
  logic [MEM_W-1:0] ram_wdata_s, ram_rdata_s;
  logic            accept_s, fault_s, par_bad_s;

  // Lifecycle FSM and fill counter next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IMEM_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = IMEM_BOOT;
        end else begin
          state_d = IMEM_INIT;
        end
      end
      IMEM_BOOT: begin
        if (boot_done_i) begin
          state_d = IMEM_RUN;
        end else begin
          state_d = IMEM_BOOT;
        end
      end
      IMEM_RUN: state_d = IMEM_RUN;
      default:  state_d = IMEM_INIT;
    endcase
  end

  // Write port: INIT fills with NOP, BOOT takes loader writes, RUN is read-only.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = cnt_q;
    wdata_raw_s = NOP_WORD;
    if (state_q == IMEM_INIT) begin
      ram_we_s = 1'b1;
    end else if ((state_q == IMEM_BOOT) && boot_we_i) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = boot_addr_i;
      wdata_raw_s = boot_data_i;
    end else begin
      ram_we_s = 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  assign ram_wdata_s = {even_parity(IMEM_PAR_MAX_W'(wdata_raw_s)), wdata_raw_s};
  assign par_bad_s   = ~nop_sel_q & (^ram_rdata_s);
`else
  assign ram_wdata_s = wdata_raw_s;
  assign par_bad_s   = 1'b0;
`endif

  // Bits above the array's span make the address out of range.
  assign accept_s = fetch_req_i & ready_q;
  assign fault_s  = (|fetch_addr_i[1:0]) | (|(fetch_addr_i >> (2 + AW)));
  assign ram_re_s = accept_s & ~fault_s;

  imem_ram_1r1w #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (ram_re_s),
    .raddr_i (fetch_addr_i[2 +: AW]),
    .rdata_o (ram_rdata_s)
  );

  // State, status flags and response bookkeeping.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IMEM_INIT;
      cnt_q        <= '0;
      boot_ready_q <= 1'b0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      nop_sel_q    <= 1'b1;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      boot_ready_q <= (state_d == IMEM_BOOT);
      ready_q      <= (state_d == IMEM_RUN);
      valid_q      <= accept_s;
      if (accept_s) begin
        nop_sel_q  <= fault_s;
        addr_err_q <= fault_s;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic parity_err_q;

  // Sticky parity fault flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_q | (valid_q & par_bad_s);
    end
  end

  assign parity_err_o = parity_err_q;
`endif

  assign boot_ready_o  = boot_ready_q;
  assign ready_o       = ready_q;
  assign fetch_gnt_o   = ready_q;
  assign fetch_valid_o = valid_q;
  assign instruction_o = nop_sel_q ? NOP_WORD : ram_rdata_s[XLEN-1:0];
  assign fetch_err_o   = addr_err_q | par_bad_s;

endmodule

// File: tb/tb_instr_mem_boot.sv
// Directed testbench for instr_mem_boot with DEPTH_WORDS=16.
// Covers the startup sequence, boot writes, fetch faults, ignored inputs and mid-BOOT reset.
module tb_instr_mem_boot;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        boot_we_i = 1'b0;
  logic [3:0]  boot_addr_i = 4'd0;
  logic [31:0] boot_data_i = 32'd0;
  logic        boot_done_i = 1'b0;
  logic        boot_ready_o, ready_o;
  logic        fetch_req_i = 1'b0;
  logic [31:0] fetch_addr_i = 32'd0;
  logic        fetch_gnt_o, fetch_valid_o, fetch_err_o;
  logic [31:0] instruction_o;
`ifdef IMEM_PARITY_EN
  logic        parity_err_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_mem_boot #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .boot_we_i     (boot_we_i),
    .boot_addr_i   (boot_addr_i),
    .boot_data_i   (boot_data_i),
    .boot_done_i   (boot_done_i),
    .boot_ready_o  (boot_ready_o),
    .ready_o       (ready_o),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_gnt_o   (fetch_gnt_o),
    .fetch_valid_o (fetch_valid_o),
    .instruction_o (instruction_o),
`ifdef IMEM_PARITY_EN
    .parity_err_o  (parity_err_o),
`endif
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_boot_ready"}, 32'(boot_ready_o), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready_o), 32'd0);
    check_eq({tag, "_gnt"}, 32'(fetch_gnt_o), 32'd0);
    check_eq({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
    check_eq({tag, "_instr"}, instruction_o, NOP);
    check_eq({tag, "_err"}, 32'(fetch_err_o), 32'd0);
  endtask

  // Releases reset and walks through INIT, checking boot_ready rises after edge DEPTH-1.
  task automatic run_init(input string tag);
    reset_i = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
    end
    check_eq({tag, "_boot_ready_e14"}, 32'(boot_ready_o), 32'd0);
    tick();
    check_eq({tag, "_boot_ready_e15"}, 32'(boot_ready_o), 32'd1);
  endtask

  task automatic boot_write(input logic [3:0] idx, input logic [31:0] data, input logic done);
    boot_we_i   = 1'b1;
    boot_addr_i = idx;
    boot_data_i = data;
    boot_done_i = done;
    tick();
    boot_we_i   = 1'b0;
    boot_done_i = 1'b0;
  endtask

  logic [31:0] f_addr [9];
  logic [31:0] f_data [9];
  logic        f_err  [9];

  initial begin
    f_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h40, 32'h8000_0000, 32'h3C, 32'h4};
    f_data = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, NOP, NOP, NOP, NOP, NOP, 32'h89AB_CDEF};
    f_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    tick();
    tick();
    check_reset_outputs("por");

    // INIT must ignore loader writes, done and fetch requests.
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h0;
    boot_we_i    = 1'b1;
    boot_addr_i  = 4'd3;
    boot_data_i  = 32'h0BAD_0BAD;
    boot_done_i  = 1'b1;
    reset_i      = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
    end
    check_eq("init_boot_ready_e14", 32'(boot_ready_o), 32'd0);
    check_eq("init_gnt", 32'(fetch_gnt_o), 32'd0);
    check_eq("init_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("init_ready", 32'(ready_o), 32'd0);
    tick();
    check_eq("init_boot_ready_e15", 32'(boot_ready_o), 32'd1);
    boot_we_i   = 1'b0;
    boot_done_i = 1'b0;

    // BOOT: fetch still dropped; last write to an index wins.
    boot_write(4'd1, 32'h1111_1111, 1'b0);
    check_eq("boot_gnt", 32'(fetch_gnt_o), 32'd0);
    check_eq("boot_valid", 32'(fetch_valid_o), 32'd0);
    boot_write(4'd0, 32'h0123_4567, 1'b0);
    boot_write(4'd1, 32'h89AB_CDEF, 1'b0);
    boot_write(4'd2, 32'hDEAD_BEEF, 1'b1);
    check_eq("run_ready", 32'(ready_o), 32'd1);
    check_eq("run_boot_ready", 32'(boot_ready_o), 32'd0);
    check_eq("run_gnt", 32'(fetch_gnt_o), 32'd1);
    check_eq("run_entry_valid", 32'(fetch_valid_o), 32'd0);

    // Back-to-back fetches: one response per edge.
    for (int i = 0; i < 9; i++) begin
      fetch_addr_i = f_addr[i];
      tick();
      check_eq($sformatf("fetch%0d_valid", i), 32'(fetch_valid_o), 32'd1);
      check_eq($sformatf("fetch%0d_instr", i), instruction_o, f_data[i]);
      check_eq($sformatf("fetch%0d_err", i), 32'(fetch_err_o), 32'(f_err[i]));
    end
    fetch_req_i = 1'b0;
    tick();
    check_eq("idle_valid", 32'(fetch_valid_o), 32'd0);
    check_eq("idle_hold_instr", instruction_o, 32'h89AB_CDEF);
    tick();
    check_eq("idle_hold_instr2", instruction_o, 32'h89AB_CDEF);

    // RUN is read-only.
    boot_write(4'd0, 32'hFFFF_FFFF, 1'b1);
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h0;
    tick();
    fetch_req_i = 1'b0;
    check_eq("ro_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("ro_instr", instruction_o, 32'h0123_4567);
    check_eq("ro_ready", 32'(ready_o), 32'd1);

`ifdef IMEM_PARITY_EN
    dut.u_ram.mem_q[3][32] = ~dut.u_ram.mem_q[3][32];
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'hC;
    tick();
    fetch_req_i = 1'b0;
    check_eq("par_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("par_err", 32'(fetch_err_o), 32'd1);
    check_eq("par_instr", instruction_o, NOP);
    tick();
    check_eq("par_sticky", 32'(parity_err_o), 32'd1);
    tick();
    check_eq("par_sticky2", 32'(parity_err_o), 32'd1);
`endif

    // Async reset from RUN.
    reset_i = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    tick();

    // Reset mid-BOOT, then a full restart wipes the boot image.
    run_init("life2");
    boot_write(4'd5, 32'hAAAA_5555, 1'b0);
    reset_i = 1'b0;
    #1;
    check_reset_outputs("rst_boot");
`ifdef IMEM_PARITY_EN
    check_eq("rst_boot_parity", 32'(parity_err_o), 32'd0);
`endif
    tick();
    run_init("life3");
    boot_write(4'd0, 32'h0, 1'b1);
    check_eq("life3_ready", 32'(ready_o), 32'd1);
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h8;
    tick();
    check_eq("life3_f8_valid", 32'(fetch_valid_o), 32'd1);
    check_eq("life3_f8_instr", instruction_o, NOP);
    check_eq("life3_f8_err", 32'(fetch_err_o), 32'd0);
    fetch_addr_i = 32'h14;
    tick();
    fetch_req_i = 1'b0;
    check_eq("life3_f14_instr", instruction_o, NOP);
    check_eq("life3_f14_err", 32'(fetch_err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
